// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES key schedule tables, state encoding and permutation helpers
package des_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // PC-1: DES bit numbers (1 = MSB of the 64-bit key); parity bits never appear
    localparam int unsigned PC1 [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: DES bit numbers (1 = MSB of the 56-bit {C,D})
    localparam int unsigned PC2 [0:47] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Left-rotation amount for C and D in each round; sums to 28
    localparam logic [1:0] SHIFTS [0:15] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // 64-bit key -> 56-bit {C,D}
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] o;
        o = '0;
        for (int i = 0; i < 56; i++) begin
            o[6'(55 - i)] = k[6'(64 - PC1[i])];
        end
        return o;
    endfunction

    // 56-bit {C,D} -> 48-bit round subkey
    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) begin
            o[6'(47 - i)] = cd[6'(56 - PC2[i])];
        end
        return o;
    endfunction

endpackage

// File: rtl/des_pc2.sv
// rtl/des_pc2.sv - combinational PC-2 permutation, 56 bits to 48 bits
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] subkey
);

    // Pure wiring permutation on the rotated C/D
    always_comb begin
        subkey = pc2(cd);
    end

endmodule

// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - iterative DES key schedule filling a 16-entry subkey bank
module des_key_schedule
    import des_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [63:0]  key,
    input  logic         decrypt,
    output logic [767:0] subkeys,
    output logic         subkeys_valid,
    output logic         busy
);

    state_t      state_q, state_d;
    logic [3:0]  r_q, r_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic        dec_q, dec_d;
    logic [47:0] bank_q [0:15];
    logic [47:0] bank_d [0:15];

    logic [27:0] c_rot, d_rot;
    logic [47:0] pc2_out;
    logic [3:0]  slot;
    logic [55:0] cd_load;

    // Rotate C/D by the amount for the current round
    always_comb begin
        if (SHIFTS[r_q] == 2'd1) begin
            c_rot = {c_q[26:0], c_q[27]};
            d_rot = {d_q[26:0], d_q[27]};
        end else begin
            c_rot = {c_q[25:0], c_q[27:26]};
            d_rot = {d_q[25:0], d_q[27:26]};
        end
    end

    des_pc2 u_pc2 (
        .cd     ({c_rot, d_rot}),
        .subkey (pc2_out)
    );

    // Decrypt stores round r into the mirrored slot so K1 input receives round 16
    always_comb begin
        slot    = dec_q ? (4'd15 - r_q) : r_q;
        cd_load = pc1(key);
    end

    // Next-state: accept in IDLE/DONE, one subkey per cycle in GEN
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        d_d     = d_q;
        dec_d   = dec_q;
        bank_d  = bank_q;
        case (state_q)
            IDLE, DONE: begin
                if (key_valid) begin
                    c_d     = cd_load[55:28];
                    d_d     = cd_load[27:0];
                    dec_d   = decrypt;
                    r_d     = 4'd0;
                    state_d = GEN;
                end
            end
            GEN: begin
                c_d          = c_rot;
                d_d          = d_rot;
                bank_d[slot] = pc2_out;
                if (r_q == 4'd15) begin
                    state_d = DONE;
                end else begin
                    r_d = r_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, round counter, C/D and subkey bank registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= 4'd0;
            c_q     <= '0;
            d_q     <= '0;
            dec_q   <= 1'b0;
            bank_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            d_q     <= d_d;
            dec_q   <= dec_d;
            bank_q  <= bank_d;
        end
    end

    // Status decoded from the state register only
    always_comb begin
        key_ready     = (state_q != GEN);
        busy          = (state_q == GEN);
        subkeys_valid = (state_q == DONE);
    end

    // Flatten the bank: slot 0 drives the most significant 48 bits (K1)
    for (genvar i = 0; i < 16; i++) begin : g_flat
        assign subkeys[767 - 48*i -: 48] = bank_q[i];
    end

endmodule

// File: tb/tb_des_key_schedule.sv
// tb/tb_des_key_schedule.sv - directed self-checking bench for des_key_schedule
module tb_des_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [63:0]  key = '0;
    logic         decrypt = 1'b0;
    logic [767:0] subkeys;
    logic         subkeys_valid;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int n;

    localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_AP = 64'h133457799BBCDFF0;
    localparam logic [47:0] K1     = 48'h1B02EFFC7072;
    localparam logic [47:0] K2     = 48'h79AED9DBC9E5;
    localparam logic [47:0] K16    = 48'hCB3D8B0E17F5;

    des_key_schedule dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_valid     (key_valid),
        .key_ready     (key_ready),
        .key           (key),
        .decrypt       (decrypt),
        .subkeys       (subkeys),
        .subkeys_valid (subkeys_valid),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] slot_of(input logic [767:0] bus, input int s);
        return bus[767 - 48*s -: 48];
    endfunction

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_key(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%012h expected=%012h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [767:0] obs, input logic [767:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [63:0] k, input logic dec);
        @(negedge clk);
        key       = k;
        decrypt   = dec;
        key_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!subkeys_valid && cnt < 40) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk_bus("reset_subkeys", subkeys, '0);
        chk_bit("reset_valid", subkeys_valid, 1'b0);
        chk_bit("reset_busy", busy, 1'b0);
        chk_bit("reset_ready", key_ready, 1'b1);
        rst_n = 1'b1;

        // Encrypt order
        send(KEY_A, 1'b0);
        chk_bit("gen_busy", busy, 1'b1);
        chk_bit("gen_ready", key_ready, 1'b0);
        wait_valid(n);
        chk_int("enc_latency", n, 16);
        chk_key("enc_k1", slot_of(subkeys, 0), K1);
        chk_key("enc_k2", slot_of(subkeys, 1), K2);
        chk_key("enc_k16", slot_of(subkeys, 15), K16);
        chk_bit("done_ready", key_ready, 1'b1);
        chk_bit("done_busy", busy, 1'b0);

        // DONE holds while key/decrypt wiggle without key_valid
        key = 64'hFFFF_0000_FFFF_0000;
        decrypt = 1'b1;
        repeat (3) @(negedge clk);
        chk_key("hold_k1", slot_of(subkeys, 0), K1);
        chk_key("hold_k16", slot_of(subkeys, 15), K16);
        chk_bit("hold_valid", subkeys_valid, 1'b1);

        // Decrypt order
        send(KEY_A, 1'b1);
        chk_bit("dec_valid_drop", subkeys_valid, 1'b0);
        wait_valid(n);
        chk_int("dec_latency", n, 16);
        chk_key("dec_slot0", slot_of(subkeys, 0), K16);
        chk_key("dec_slot14", slot_of(subkeys, 14), K2);
        chk_key("dec_slot15", slot_of(subkeys, 15), K1);

        // Parity bit ignored
        send(KEY_AP, 1'b0);
        wait_valid(n);
        chk_key("par_k1", slot_of(subkeys, 0), K1);
        chk_key("par_k2", slot_of(subkeys, 1), K2);
        chk_key("par_k16", slot_of(subkeys, 15), K16);

        // Back-to-back with key_valid held high
        @(negedge clk);
        key       = 64'h0;
        decrypt   = 1'b0;
        key_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        key = 64'hFFFF_FFFF_FFFF_FFFF;
        wait_valid(n);
        chk_int("b2b_first_latency", n, 16);
        chk_bus("b2b_zero_bank", subkeys, '0);
        chk_bit("b2b_done_ready", key_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        key_valid = 1'b0;
        chk_bit("b2b_second_accept", subkeys_valid, 1'b0);
        chk_bit("b2b_second_busy", busy, 1'b1);
        wait_valid(n);
        chk_int("b2b_gap", n, 16);
        chk_bus("b2b_ones_bank", subkeys, {768{1'b1}});

        // Reset in the middle of generation (r = 7)
        send(KEY_A, 1'b0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk_bit("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_bus("rst_subkeys", subkeys, '0);
        chk_bit("rst_valid", subkeys_valid, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_ready", key_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        send(KEY_A, 1'b0);
        wait_valid(n);
        chk_int("post_rst_latency", n, 16);
        chk_key("post_rst_k1", slot_of(subkeys, 0), K1);
        chk_key("post_rst_k16", slot_of(subkeys, 15), K16);

        // key_valid during GEN is ignored
        send(KEY_A, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            if (i == 5) begin
                key       = 64'hFFFF_FFFF_FFFF_FFFF;
                decrypt   = 1'b1;
                key_valid = 1'b1;
            end else begin
                key_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            chk_bit($sformatf("gen_ready_%0d", i), key_ready, 1'b0);
        end
        key_valid = 1'b0;
        wait_valid(n);
        chk_int("ign_tail", n, 1);
        chk_key("ign_k1", slot_of(subkeys, 0), K1);
        chk_key("ign_k2", slot_of(subkeys, 1), K2);
        chk_key("ign_k16", slot_of(subkeys, 15), K16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
